// File: rtl/sync_mem_bank_if.sv
// Request/response bus of sync_mem_bank: valid/ready request channel plus
// an unbackpressured read response channel and the clear-sweep status flag.
interface sync_mem_bank_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/sync_mem_bank.sv
// Single-port synchronous data memory with byte strobes, one-cycle read response and a
// post-reset clear sweep. Optional per-byte even parity is enabled by defining MEM_PARITY_EN.
module sync_mem_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input logic            clk,
    input logic            rst,
    sync_mem_bank_if.slave bus_io
);

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    // Storage has no reset; it is cleared by the sweep instead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              in_range;
    logic              hs;
    logic              wr_en;
    logic              rd_en;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_idx;
    logic [STRB_W-1:0] wr_be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_word;
    logic              par_err;

    assign in_range = (32'(bus_io.req_addr) < DEPTH);
    assign hs       = bus_io.req_valid & ready_q;
    assign wr_en    = hs & bus_io.req_we & in_range;
    assign rd_en    = hs & ~bus_io.req_we;
    assign rd_word  = in_range ? mem_q[bus_io.req_addr] : '0;

    always_comb begin
        mem_we  = wr_en;
        wr_idx  = bus_io.req_addr;
        wr_be   = bus_io.req_wstrb;
        wr_data = bus_io.req_wdata;
        if (state_q == StInit) begin
            mem_we  = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_be   = '1;
            wr_data = '0;
        end
    end

`ifdef MEM_PARITY_EN
    logic [STRB_W-1:0] par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                    par_q[wr_idx][i]        <= ^wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        par_err = 1'b0;
        if (in_range) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                par_err = par_err | ((^rd_word[8*i +: 8]) != par_q[bus_io.req_addr][i]);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StInit;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: ready_q <= 1'b1;
                default: state_q <= StInit;
            endcase
            rsp_valid_q <= rd_en;
            // rdata holds between responses; err only qualifies a live response.
            if (rd_en) begin
                rsp_rdata_q <= rd_word;
                rsp_err_q   <= ~in_range | par_err;
            end else begin
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign bus_io.req_ready = ready_q;
    assign bus_io.init_done = ready_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sync_mem_bank.sv
// Bench for sync_mem_bank: two instances (DEPTH 32 and 20) share one stimulus stream and are
// each compared against an array-based reference model of the memory.
module tb_sync_mem_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [4:0]  req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;

    sync_mem_bank_if #(.DATA_W(32), .DEPTH(32)) bus_a ();
    sync_mem_bank_if #(.DATA_W(32), .DEPTH(20)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_we    = req_we;
    assign bus_a.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_a.req_wstrb = req_wstrb;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_we    = req_we;
    assign bus_b.req_addr  = req_addr;
    assign bus_b.req_wdata = req_wdata;
    assign bus_b.req_wstrb = req_wstrb;

    sync_mem_bank #(.DATA_W(32), .DEPTH(32)) dut_a (.clk(clk), .rst(rst), .bus_io(bus_a));
    sync_mem_bank #(.DATA_W(32), .DEPTH(20)) dut_b (.clk(clk), .rst(rst), .bus_io(bus_b));

    logic [1:0]  o_valid, o_err, o_ready, o_done;
    logic [31:0] o_data [2];
    assign o_valid   = {bus_b.rsp_valid, bus_a.rsp_valid};
    assign o_err     = {bus_b.rsp_err,   bus_a.rsp_err};
    assign o_ready   = {bus_b.req_ready, bus_a.req_ready};
    assign o_done    = {bus_b.init_done, bus_a.init_done};
    assign o_data[0] = bus_a.rsp_rdata;
    assign o_data[1] = bus_b.rsp_rdata;

    int unsigned depth [2] = '{32, 20};
    logic [31:0] model [2][32];
    logic [31:0] corrupt [2];
    logic [1:0]  ready_m;
    logic [1:0]  exp_v, exp_e;
    logic [31:0] exp_d [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int d, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[depth%0d]: observed=%h expected=%h", tag, depth[d], obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (ready_m[d] && req_valid) begin
                logic inr = (32'(req_addr) < depth[d]);
                if (req_we) begin
                    exp_v[d] = 1'b0;
                    exp_e[d] = 1'b0;
                    if (inr) begin
                        model[d][req_addr] = merge(model[d][req_addr], req_wdata, req_wstrb);
                        if (req_wstrb[0]) corrupt[d][req_addr] = 1'b0;
                    end
                end else begin
                    exp_v[d] = 1'b1;
                    exp_d[d] = inr ? model[d][req_addr] : 32'h0;
                    exp_e[d] = !inr || corrupt[d][req_addr];
                end
            end else begin
                exp_v[d] = 1'b0;
                exp_e[d] = 1'b0;
            end
        end
    endtask

    // Called at a negedge: drive, take one rising edge, then compare at the next negedge.
    task automatic step(input logic v, input logic we, input logic [4:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = ws;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rsp_valid", d, 32'(o_valid[d]), 32'(exp_v[d]));
            check("rsp_err",   d, 32'(o_err[d]),   32'(exp_e[d]));
            check("rsp_rdata", d, o_data[d],       exp_d[d]);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) model[d][i] = 32'h0;
            corrupt[d] = '0;
            exp_d[d]   = 32'h0;
            check("rst_ready", d, 32'(o_ready[d]), 32'h0);
            check("rst_done",  d, 32'(o_done[d]),  32'h0);
            check("rst_valid", d, 32'(o_valid[d]), 32'h0);
            check("rst_err",   d, 32'(o_err[d]),   32'h0);
            check("rst_rdata", d, o_data[d],       32'h0);
        end
        ready_m = '0;
        exp_v   = '0;
        exp_e   = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic up = (k >= int'(depth[d]));
                check("init_done", d, 32'(o_done[d]),  32'(up));
                check("req_ready", d, 32'(o_ready[d]), 32'(up));
                check("idle_valid", d, 32'(o_valid[d]), 32'h0);
                ready_m[d] = up;
            end
        end
    endtask

    initial begin
        ready_m = '0;
        exp_v   = '0;
        exp_e   = '0;
        @(negedge clk);
        do_reset();

        // Full sweep read-back: everything cleared; depth-20 instance flags the top 12.
        for (int a = 0; a < 32; a++) step(1'b1, 1'b0, 5'(a), 32'h0, 4'h0);

        step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
        step(1'b1, 1'b1, 5'd5, 32'h00001200, 4'b0010);
        step(1'b1, 1'b0, 5'd5, 32'h0, 4'h0);
        check("merge_const", 0, o_data[0], 32'hDEAD12EF);
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        check("hold_rdata", 0, o_data[0], 32'hDEAD12EF);

        step(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 4'hF);
        step(1'b1, 1'b0, 5'd7, 32'h0, 4'h0);
        check("raw_const", 0, o_data[0], 32'hA5A5A5A5);
        for (int a = 0; a < 3; a++) step(1'b1, 1'b0, 5'(a), 32'h0, 4'h0);

        step(1'b1, 1'b1, 5'd6, 32'h11223344, 4'h0);
        step(1'b1, 1'b0, 5'd6, 32'h0, 4'h0);

        step(1'b1, 1'b1, 5'd25, 32'h12345678, 4'hF);
        step(1'b1, 1'b0, 5'd25, 32'h0, 4'h0);
        check("oor_err", 1, 32'(o_err[1]), 32'h1);
        check("oor_rdata", 1, o_data[1], 32'h0);
        step(1'b1, 1'b0, 5'd19, 32'h0, 4'h0);

        step(1'b1, 1'b1, 5'd3, 32'h0F0F0F0F, 4'hF);
`ifdef MEM_PARITY_EN
        dut_a.mem_q[3][0] <= ~dut_a.mem_q[3][0];
        dut_b.mem_q[3][0] <= ~dut_b.mem_q[3][0];
        for (int d = 0; d < 2; d++) begin
            model[d][3][0] = ~model[d][3][0];
            corrupt[d][3]  = 1'b1;
        end
        #1;
`endif
        step(1'b1, 1'b0, 5'd3, 32'h0, 4'h0);

        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
        end

        // Read accepted, then reset lands before its response can be consumed.
        step(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 4'hF);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 5'd9;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_valid", 0, 32'(o_valid[0]), 32'h0);
        check("abort_valid", 1, 32'(o_valid[1]), 32'h0);
        @(negedge clk);
        do_reset();
        step(1'b1, 1'b0, 5'd9, 32'h0, 4'h0);
        check("post_rst_rdata", 0, o_data[0], 32'h0);
        step(1'b1, 1'b0, 5'd5, 32'h0, 4'h0);
        step(1'b1, 1'b0, 5'd7, 32'h0, 4'h0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
